// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/LSU memory port arbiter.
// Requester IDs double as bit positions in the request/grant vectors.
package mem_port_arbiter_pkg;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The caller owns the last_grant and lock state registers.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  input  logic               lock,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock) begin
      // A locked LSU owns the port outright; IF waits even when LSU is idle.
      gnt[REQ_LSU] = req[REQ_LSU];
    end else if (req[REQ_IF] && req[REQ_LSU]) begin
      if (last_grant == REQ_LSU) gnt[REQ_IF] = 1'b1;
      else                       gnt[REQ_LSU] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-write/single-read memory between instruction fetch and the LSU.
// One access per cycle, grant is combinational, read data returns one cycle after grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic                  lsu_lock_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  last_grant;
  logic                  lock_owner;
  logic                  if_rvalid_q;
  logic                  lsu_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] lsu_rdata_q;
  logic                  lsu_read_gnt;

  // Requests are masked during reset so nothing, in particular a write, is issued.
  assign req = {lsu_req_i, if_req_i} & {NUM_REQ{~rst_i}};

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .lock       (lock_owner),
    .gnt        (gnt)
  );

  assign if_gnt_o     = gnt[REQ_IF];
  assign lsu_gnt_o    = gnt[REQ_LSU];
  assign lsu_read_gnt = gnt[REQ_LSU] & ~lsu_we_i;

  always_comb begin
    mem_wr_o    = 1'b0;
    mem_waddr_o = '0;
    mem_raddr_o = '0;
    mem_wdata_o = '0;
    if (gnt[REQ_LSU] && lsu_we_i) begin
      mem_wr_o    = 1'b1;
      mem_waddr_o = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end else if (gnt[REQ_LSU]) begin
      mem_raddr_o = lsu_addr_i;
    end else if (gnt[REQ_IF]) begin
      mem_raddr_o = if_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant   <= REQ_LSU;
      lock_owner   <= 1'b0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      if (|gnt) last_grant <= gnt[REQ_LSU] ? REQ_LSU : REQ_IF;
      if (gnt[REQ_LSU]) lock_owner <= lsu_lock_i;
      if_rvalid_q  <= gnt[REQ_IF];
      lsu_rvalid_q <= lsu_read_gnt;
      if (gnt[REQ_IF]) if_rdata_q <= mem_rdata_i;
      if (lsu_read_gnt) lsu_rdata_q <= mem_rdata_i;
    end
  end

  // A response registered just before reset must not be seen while reset is asserted.
  assign if_rvalid_o  = if_rvalid_q & ~rst_i;
  assign lsu_rvalid_o = lsu_rvalid_q & ~rst_i;
  assign if_rdata_o   = if_rdata_q;
  assign lsu_rdata_o  = lsu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, lock and memory contents.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic ID_IF  = 1'b0;
  localparam logic ID_LSU = 1'b1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          lsu_req = 1'b0;
  logic          lsu_we = 1'b0;
  logic          lsu_lock = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          lsu_gnt;
  logic          lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_wr;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .lsu_req_i    (lsu_req),
    .lsu_we_i     (lsu_we),
    .lsu_lock_i   (lsu_lock),
    .lsu_addr_i   (lsu_addr),
    .lsu_wdata_i  (lsu_wdata),
    .lsu_gnt_o    (lsu_gnt),
    .lsu_rvalid_o (lsu_rvalid),
    .lsu_rdata_o  (lsu_rdata),
    .mem_wr_o     (mem_wr),
    .mem_waddr_o  (mem_waddr),
    .mem_raddr_o  (mem_raddr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 8'h05) return 32'hDEADBEEF;
    return {24'h5A5A5A, a};
  endfunction

  // Environment memory: reloaded with a known pattern whenever reset is held.
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= init_word(AW'(i));
    end else if (mem_wr) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_lock = 1'b0; lsu_addr = '0; lsu_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({if_rvalid, lsu_rvalid} !== 2'b00) begin
      miscompares++; $display("FAIL reset_rvalid got=%b exp=00", {if_rvalid, lsu_rvalid});
    end
    vectors++;
    if ({if_rdata, lsu_rdata} !== 64'h0) begin
      miscompares++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, lsu_rdata);
    end
    vectors++;
    if ({if_gnt, lsu_gnt, mem_wr} !== 3'b000) begin
      miscompares++; $display("FAIL reset_idle got=%b exp=000", {if_gnt, lsu_gnt, mem_wr});
    end
    next_cycle();
  endtask

  task automatic test_if_read();
    do_reset();
    if_req = 1'b1; if_addr = 8'h05;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b10 || mem_raddr !== 8'h05 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL if_read_grant got gnt=%b raddr=%h wr=%b exp gnt=10 raddr=05 wr=0",
               {if_gnt, lsu_gnt}, mem_raddr, mem_wr);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || lsu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL if_read_data got rv=%b data=%h lsu_rv=%b exp rv=1 data=deadbeef lsu_rv=0",
               if_rvalid, if_rdata, lsu_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic exp_if;
    do_reset();
    if_req = 1'b1; if_addr = 8'h01;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 8'h02;
    for (int k = 0; k < 6; k++) begin
      exp_if = (k % 2 == 0);
      @(negedge clk);
      vectors++;
      if ({if_gnt, lsu_gnt} !== {exp_if, !exp_if}) begin
        miscompares++; $display("FAIL alt_grant[%0d] got=%b exp=%b", k, {if_gnt, lsu_gnt}, {exp_if, !exp_if});
      end
      if (k > 0) begin
        vectors++;
        if ({if_rvalid, lsu_rvalid} !== {!exp_if, exp_if}) begin
          miscompares++; $display("FAIL alt_rvalid[%0d] got=%b exp=%b", k, {if_rvalid, lsu_rvalid}, {!exp_if, exp_if});
        end
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (if_rdata !== init_word(8'h01) || lsu_rdata !== init_word(8'h02)) begin
      miscompares++;
      $display("FAIL alt_rdata got=%h/%h exp=%h/%h", if_rdata, lsu_rdata, init_word(8'h01), init_word(8'h02));
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 8'h10; lsu_wdata = 32'h12345678;
    @(negedge clk);
    vectors++;
    if (lsu_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_waddr !== 8'h10 || mem_wdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL raw_write got gnt=%b wr=%b waddr=%h wdata=%h exp 1 1 10 12345678",
               lsu_gnt, mem_wr, mem_waddr, mem_wdata);
    end
    next_cycle();
    clear_inputs();
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    vectors++;
    if (if_gnt !== 1'b1 || lsu_rvalid !== 1'b0 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_read got gnt=%b lsu_rv=%b wr=%b exp 1 0 0", if_gnt, lsu_rvalid, mem_wr);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vectors++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678) begin
      miscompares++; $display("FAIL raw_data got rv=%b data=%h exp rv=1 data=12345678", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_lock();
    do_reset();
    if_req = 1'b1; if_addr = 8'h30;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_lock = 1'b1; lsu_addr = 8'h20;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b10) begin
      miscompares++; $display("FAIL lock_c0 got=%b exp=10", {if_gnt, lsu_gnt});
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b01) begin
      miscompares++; $display("FAIL lock_c1 got=%b exp=01", {if_gnt, lsu_gnt});
    end
    next_cycle();
    lsu_req = 1'b0; lsu_lock = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b00 || lsu_rvalid !== 1'b1 || lsu_rdata !== init_word(8'h20)) begin
      miscompares++;
      $display("FAIL lock_idle got gnt=%b lsu_rv=%b data=%h exp gnt=00 rv=1 data=%h",
               {if_gnt, lsu_gnt}, lsu_rvalid, lsu_rdata, init_word(8'h20));
    end
    next_cycle();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_lock = 1'b0; lsu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b01 || mem_wr !== 1'b1) begin
      miscompares++; $display("FAIL lock_unlock got gnt=%b wr=%b exp gnt=01 wr=1", {if_gnt, lsu_gnt}, mem_wr);
    end
    next_cycle();
    lsu_req = 1'b0; lsu_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b10) begin
      miscompares++; $display("FAIL lock_release got=%b exp=10", {if_gnt, lsu_gnt});
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_lock = 1'b1; lsu_addr = 8'h03;
    @(negedge clk);
    vectors++;
    if (lsu_gnt !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_grant got=%b exp=1", lsu_gnt);
    end
    next_cycle();
    rst_i = 1'b1;
    lsu_we = 1'b1; lsu_lock = 1'b0; lsu_addr = 8'h07; lsu_wdata = 32'hBADC0DE0;
    @(negedge clk);
    vectors++;
    if ({lsu_rvalid, if_rvalid, mem_wr, lsu_gnt} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_hold got rv=%b if_rv=%b wr=%b gnt=%b exp all 0", lsu_rvalid, if_rvalid, mem_wr, lsu_gnt);
    end
    next_cycle();
    rst_i = 1'b0;
    if_req = 1'b1; if_addr = 8'h04;
    lsu_we = 1'b0; lsu_addr = 8'h03;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b10 || lsu_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_tie got gnt=%b lsu_rv=%b exp gnt=10 lsu_rv=0", {if_gnt, lsu_gnt}, lsu_rvalid);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_idle();
    do_reset();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 8'h09; lsu_wdata = 32'h0BADF00D;
    @(negedge clk);
    vectors++;
    if (lsu_gnt !== 1'b1) begin
      miscompares++; $display("FAIL idle_setup got=%b exp=1", lsu_gnt);
    end
    next_cycle();
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({if_gnt, lsu_gnt, mem_wr, if_rvalid, lsu_rvalid} !== 5'b00000 ||
          mem_waddr !== '0 || mem_raddr !== '0 || mem_wdata !== '0) begin
        miscompares++;
        $display("FAIL idle[%0d] got gnt=%b wr=%b rv=%b wa=%h ra=%h wd=%h exp all 0", k,
                 {if_gnt, lsu_gnt}, mem_wr, {if_rvalid, lsu_rvalid}, mem_waddr, mem_raddr, mem_wdata);
      end
      next_cycle();
    end
    if_req = 1'b1; if_addr = 8'h09;
    lsu_req = 1'b1; lsu_addr = 8'h01;
    @(negedge clk);
    vectors++;
    if ({if_gnt, lsu_gnt} !== 2'b10) begin
      miscompares++; $display("FAIL idle_tie got=%b exp=10", {if_gnt, lsu_gnt});
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic          if_hold, lsu_hold;
    logic          m_last, m_lock, g_if, g_lsu;
    logic          e_if_rv, e_lsu_rv;
    logic [DW-1:0] e_if_d, e_lsu_d;
    do_reset();
    if_hold = 1'b0; lsu_hold = 1'b0;
    m_last = ID_LSU; m_lock = 1'b0;
    e_if_rv = 1'b0; e_lsu_rv = 1'b0; e_if_d = '0; e_lsu_d = '0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(AW'(i));
    for (int c = 0; c < 400; c++) begin
      if (!if_hold) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = AW'($urandom_range(0, 15));
      end
      if (!lsu_hold) begin
        lsu_req   = 1'($urandom_range(0, 1));
        lsu_we    = 1'($urandom_range(0, 1));
        lsu_lock  = ($urandom_range(0, 3) == 0);
        lsu_addr  = AW'($urandom_range(0, 15));
        lsu_wdata = $urandom;
      end
      if (m_lock) begin
        g_if = 1'b0; g_lsu = lsu_req;
      end else if (if_req && lsu_req) begin
        g_if  = (m_last != ID_IF);
        g_lsu = (m_last != ID_LSU);
      end else begin
        g_if = if_req; g_lsu = lsu_req;
      end
      @(negedge clk);
      vectors++;
      if ({if_gnt, lsu_gnt} !== {g_if, g_lsu}) begin
        miscompares++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, {if_gnt, lsu_gnt}, {g_if, g_lsu});
      end
      vectors++;
      if (mem_wr !== (g_lsu && lsu_we)) begin
        miscompares++; $display("FAIL rand_wr c=%0d got=%b exp=%b", c, mem_wr, g_lsu && lsu_we);
      end
      if (g_lsu && lsu_we) begin
        vectors++;
        if (mem_waddr !== lsu_addr || mem_wdata !== lsu_wdata) begin
          miscompares++;
          $display("FAIL rand_wbus c=%0d got=%h/%h exp=%h/%h", c, mem_waddr, mem_wdata, lsu_addr, lsu_wdata);
        end
      end else if (g_lsu || g_if) begin
        vectors++;
        if (mem_raddr !== (g_lsu ? lsu_addr : if_addr)) begin
          miscompares++;
          $display("FAIL rand_raddr c=%0d got=%h exp=%h", c, mem_raddr, g_lsu ? lsu_addr : if_addr);
        end
      end
      vectors++;
      if ({if_rvalid, lsu_rvalid} !== {e_if_rv, e_lsu_rv}) begin
        miscompares++; $display("FAIL rand_rvalid c=%0d got=%b exp=%b", c, {if_rvalid, lsu_rvalid}, {e_if_rv, e_lsu_rv});
      end
      vectors++;
      if (if_rdata !== e_if_d || lsu_rdata !== e_lsu_d) begin
        miscompares++;
        $display("FAIL rand_rdata c=%0d got=%h/%h exp=%h/%h", c, if_rdata, lsu_rdata, e_if_d, e_lsu_d);
      end
      e_if_rv  = g_if;
      e_lsu_rv = g_lsu && !lsu_we;
      if (g_if) e_if_d = ref_mem[if_addr];
      if (g_lsu && !lsu_we) e_lsu_d = ref_mem[lsu_addr];
      if (g_lsu && lsu_we) ref_mem[lsu_addr] = lsu_wdata;
      if (g_lsu) m_lock = lsu_lock;
      if (g_if) m_last = ID_IF;
      else if (g_lsu) m_last = ID_LSU;
      if_hold  = if_req && !g_if;
      lsu_hold = lsu_req && !g_lsu;
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_alternate();
    test_back_to_back();
    test_lock();
    test_reset_mid();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
